// File: rtl/serial_adder_pkg.sv
// Shared constants for the bit-serial adder controller: FSM encodings and default width.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] RUN  = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

endpackage

// File: rtl/full_adder_bit.sv
// One-bit full adder built from two half adders; the only arithmetic primitive
// used by the serial adder controller.
module half_adder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);

  assign s = x ^ y;
  assign c = x & y;

endmodule

module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic s0;
  logic c0;
  logic c1;

  half_adder u_ha0 (.x(a),  .y(b),   .s(s0), .c(c0));
  half_adder u_ha1 (.x(s0), .y(cin), .s(s),  .c(c1));

  assign cout = c0 | c1;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial unsigned adder: latches two operands, adds one bit per cycle LSB
// first, then publishes {cout, sum} with a single-cycle done pulse.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [WIDTH-1:0] res_next;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_inc;
  logic [CW:0]      inc_c;
  logic             cnt_wrap_unused;
  logic             fa_s;
  logic             fa_c;

  full_adder_bit u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_c)
  );

  // Counter increment is a ripple of full adders with a constant carry-in,
  // so the datapath stays free of '+'.
  assign inc_c[0] = 1'b1;
  for (genvar i = 0; i < CW; i++) begin : g_cnt_inc
    full_adder_bit u_inc (
      .a    (cnt[i]),
      .b    (1'b0),
      .cin  (inc_c[i]),
      .s    (cnt_inc[i]),
      .cout (inc_c[i+1])
    );
  end
  assign cnt_wrap_unused = inc_c[CW];

  assign res_next = {fa_s, res_sh[WIDTH-1:1]};

  always_comb begin
    state_next = IDLE;
    case (state)
      IDLE:    state_next = start ? RUN : IDLE;
      RUN:     state_next = (cnt == LAST) ? DONE : RUN;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // busy/done are registered from the next-state decode so outputs come straight from flops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else begin
      state <= state_next;
      busy  <= (state_next == RUN);
      done  <= (state_next == DONE);
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_sh   <= a;
            b_sh   <= b;
            res_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
          end
        end
        RUN: begin
          a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
          res_sh <= res_next;
          carry  <= fa_c;
          cnt    <= cnt_inc;
          if (cnt == LAST) begin
            sum  <= res_next;
            cout <= fa_c;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8): table vectors with latency
// checks, directed corner sequences, and a random sweep against a result scoreboard.
module tb_serial_adder_ctrl;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] s;
    logic         c;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int           n_checks = 0;
  int           n_errors = 0;
  int           n_done   = 0;
  int           n_push   = 0;
  logic [W:0]   sb[$];
  logic         prev_done = 1'b0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [W:0] e);
    sb.push_back(e);
    n_push++;
  endtask

  task automatic wait_done(input int limit, output int cycles, output bit ok);
    ok = 1'b0;
    cycles = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      cycles++;
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      n_errors++;
      $display("FAIL done_timeout: got no done within %0d cycles, expected done", limit);
    end
  endtask

  // Scoreboard side: every done pulse must match the oldest pending expected result.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      n_done++;
      check("done_single_cycle", prev_done, 1'b0);
      check("busy_low_in_done", busy, 1'b0);
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_done: got done=1, expected no pending operation");
      end else begin
        check("result", {cout, sum}, sb.pop_front());
      end
    end
    prev_done = done;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t         vecs[6];
    logic [W:0]   held;
    logic [W-1:0] x;
    logic [W-1:0] y;
    int           cyc;
    int           d0;
    bit           ok;

    vecs[0] = '{a: 8'h00, b: 8'h00, s: 8'h00, c: 1'b0};
    vecs[1] = '{a: 8'hFF, b: 8'h01, s: 8'h00, c: 1'b1};
    vecs[2] = '{a: 8'hA5, b: 8'h5A, s: 8'hFF, c: 1'b0};
    vecs[3] = '{a: 8'h80, b: 8'h80, s: 8'h00, c: 1'b1};
    vecs[4] = '{a: 8'h7F, b: 8'h01, s: 8'h80, c: 1'b0};
    vecs[5] = '{a: 8'hFF, b: 8'hFF, s: 8'hFE, c: 1'b1};

    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_sum",  sum,  8'h00);
    check("reset_cout", cout, 1'b0);

    // start coinciding with reset is dropped
    start = 1'b1;
    a = 8'hFF;
    b = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;
    check("start_in_reset_busy", busy, 1'b0);
    @(negedge clk);
    check("start_in_reset_idle", busy, 1'b0);

    held = '0;
    foreach (vecs[v]) begin
      start = 1'b1;
      a = vecs[v].a;
      b = vecs[v].b;
      push_exp({vecs[v].c, vecs[v].s});
      @(negedge clk);
      start = 1'b0;
      a = ~vecs[v].a;
      b = ~vecs[v].b;
      for (int k = 1; k <= W; k++) begin
        check("busy_run", busy, 1'b1);
        check("no_done_in_run", done, 1'b0);
        check("result_hold_in_run", {cout, sum}, held);
        if (k < W) @(negedge clk);
      end
      @(negedge clk);
      check("done_latency", done, 1'b1);
      held = {vecs[v].c, vecs[v].s};
      @(negedge clk);
      check("idle_busy", busy, 1'b0);
      check("idle_done", done, 1'b0);
    end

    // start pulse in RUN is ignored
    start = 1'b1;
    a = 8'h12;
    b = 8'h34;
    push_exp(9'h046);
    d0 = n_done;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1;
    a = 8'h11;
    b = 8'h22;
    @(negedge clk);
    start = 1'b0;
    wait_done(W + 4, cyc, ok);
    repeat (15) @(negedge clk);
    check("ignored_start_one_done", n_done - d0, 1);

    // start held through DONE: back-to-back with no IDLE cycle
    start = 1'b1;
    a = 8'hC3;
    b = 8'h3C;
    push_exp(9'h0FF);
    @(negedge clk);
    start = 1'b0;
    repeat (W - 1) @(negedge clk);
    start = 1'b1;
    a = 8'h80;
    b = 8'h80;
    push_exp(9'h100);
    @(negedge clk);
    check("b2b_first_done", done, 1'b1);
    @(negedge clk);
    check("b2b_no_idle", busy, 1'b1);
    start = 1'b0;
    wait_done(W + 4, cyc, ok);
    check("b2b_done_spacing", cyc + 1, 9);
    @(negedge clk);

    // reset in the 4th RUN cycle aborts the operation
    start = 1'b1;
    a = 8'h5A;
    b = 8'hA5;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_sum",  sum,  8'h00);
    check("abort_cout", cout, 1'b0);
    rst_n = 1'b1;
    d0 = n_done;
    repeat (20) @(negedge clk);
    check("abort_no_done", n_done - d0, 0);

    for (int i = 0; i < 1000; i++) begin
      x = W'($urandom);
      y = W'($urandom);
      start = 1'b1;
      a = x;
      b = y;
      push_exp({1'b0, x} + {1'b0, y});
      @(negedge clk);
      start = 1'b0;
      a = W'($urandom);
      b = W'($urandom);
      wait_done(W + 4, cyc, ok);
    end
    repeat (4) @(negedge clk);
    check("done_per_accept", n_done, n_push);
    check("scoreboard_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: operand and result width in bits, legal range 2..32.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  reset, synchronous, active-low, one clock domain.
REQ-004 start  input  1  request a new addition; sampled only in IDLE or DONE.
REQ-005 a  input  WIDTH  operand A; sampled on the cycle start is accepted.
REQ-006 b  input  WIDTH  operand B; sampled on the cycle start is accepted.
REQ-007 busy  output  1  high while state is RUN.
REQ-008 done  output  1  single-cycle pulse, high while state is DONE.
REQ-009 sum  output  WIDTH  registered result of the last completed addition.
REQ-010 cout  output  1  registered carry-out of the last completed addition.

Function
REQ-011 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-012 Accept: if start=1 in IDLE or DONE, latch a/b into shift registers, clear carry, set bit counter to 0, and go to RUN.
REQ-013 RUN SHALL add one bit per cycle, LSB first: s_i = a_i ^ b_i ^ c, c_next = majority(a_i, b_i, c), computed by one full-adder bit.
REQ-014 Each RUN cycle SHALL shift s_i into the MSB of an internal result shift register, shift the operands right by one, and increment the counter.
REQ-015 RUN -> DONE after exactly WIDTH RUN cycles, when counter = WIDTH-1.
REQ-016 On the DONE entry edge, sum SHALL load the internal result register and cout SHALL load the final carry.
REQ-017 Latency: start accepted at cycle T; RUN at T+1..T+WIDTH; done=1 at T+WIDTH+1; sum and cout valid from T+WIDTH+1.
REQ-018 DONE -> RUN if start=1, otherwise DONE -> IDLE; DONE SHALL last exactly one cycle.
REQ-019 start during RUN SHALL be ignored: operands, counter and result are unaffected, and no request is queued.
REQ-020 sum and cout SHALL hold their value until the next DONE entry; they do not change during RUN.
REQ-021 a and b SHALL be don't-care except on the accept cycle.
REQ-022 Arithmetic is unsigned modulo 2^WIDTH; overflow is reported only through cout.

Reset
REQ-023 rst_n=0 at a clock edge SHALL force state IDLE, busy=0, done=0, sum=0, cout=0, counter=0, carry=0, and clear the shift registers.
REQ-024 Reset during RUN SHALL abort the operation: no done pulse, and sum/cout SHALL read 0.
REQ-025 A start asserted in the same cycle as rst_n=0 SHALL be ignored.

Structure
REQ-026 Shared package serial_adder_pkg SHALL hold the state encoding constants (IDLE=2'b00, RUN=2'b01, DONE=2'b10) and DEFAULT_WIDTH=8.
REQ-027 Sub-module full_adder_bit SHALL implement the per-bit add from two half_adder instances plus an OR of their carries.
REQ-028 All arithmetic SHALL go through full_adder_bit; no '+' operator in serial_adder_ctrl.
REQ-029 Outputs SHALL be driven directly from flops, with no combinational path from inputs to outputs.

Verification (WIDTH=8)
REQ-030 Start with a=8'h00, b=8'h00 at cycle T -> busy at T+1..T+8, done at T+9, sum=8'h00, cout=0.
REQ-031 a=8'hFF, b=8'h01 -> sum=8'h00, cout=1; a=8'hA5, b=8'h5A -> sum=8'hFF, cout=0.
REQ-032 During RUN, start pulsed with a=8'h11, b=8'h22 -> ignored; result reflects the original operands and exactly one done pulse.
REQ-033 start held high through DONE with new operands 8'h80+8'h80 -> RUN resumes with no IDLE cycle; second done 9 cycles after the first; sum=8'h00, cout=1.
REQ-034 rst_n=0 at the 4th RUN cycle -> next cycle IDLE, busy=0, sum=0, cout=0, and no done for 20 cycles after release.
REQ-035 Random sweep of 1000 operand pairs -> {cout,sum} == a+b for every pair, with done exactly once per accepted start.
